capture_ctrl: RTL

- Capture sequencer that consumes the combined channel trigger and drives `armed` back to the per-channel trigger detectors.
- Generates write-enable and circular addresses for the sample RAM.
- Fills a pre-trigger window, arms, waits for a trigger, captures a programmable number of post-trigger samples, then reports done.
- Sits between the command/register block and the per-channel trigger detectors plus the sample RAM.

---
 rtl/capture_pkg.sv | 21 ++
 rtl/capture_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/capture_pkg.sv
// Shared capture sequencer definitions: state encoding, default RAM depth and
// the pre-trigger target calculation.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    DONE
  } cap_state_t;

  localparam int unsigned CAP_DEPTH_DEFAULT = 512;

  // Number of pre-trigger writes before arming; trig_pos beyond DEPTH-1 saturates to 0.
  function automatic int unsigned calc_pre_tgt(input int unsigned depth,
                                               input int unsigned tpos);
    return (tpos >= depth - 1) ? 0 : depth - 1 - tpos;
  endfunction

endpackage

// File: rtl/capture_ctrl.sv
// Capture sequencer: pre-trigger fill, arm, trigger, post-trigger count, done.
// Optional auto-trigger timeout in ARMED is enabled by defining CAPTURE_AUTO_TRIG_EN.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned DEPTH        = CAP_DEPTH_DEFAULT,
  parameter int unsigned AW           = $clog2(DEPTH),
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          smpl_en,
  input  logic          trig_in,
  input  logic [AW-1:0] trig_pos,
  output logic          armed,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] trig_addr,
  output logic          triggered,
  output logic          capture_done
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AUTO_TIMEOUT < 2) begin : g_param_check
    $error("capture_ctrl: DEPTH must be a power of two >= 4 and AUTO_TIMEOUT >= 2");
  end

  cap_state_t    state;
  cap_state_t    state_next;
  logic [AW-1:0] pre_cnt;
  logic [AW-1:0] post_cnt;
  logic [AW-1:0] tp_lat;
  logic [AW-1:0] pre_tgt;
  logic [AW-1:0] start_pre_tgt;
  logic          start_ok;
  logic          trig_take;
  logic          auto_fire;

  assign start_ok      = start && !abort && (state == IDLE || state == DONE);
  assign start_pre_tgt = AW'(calc_pre_tgt(DEPTH, 32'(trig_pos)));
  assign trig_take     = (state == ARMED) && smpl_en && (trig_in || auto_fire);

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam int unsigned TW = $clog2(AUTO_TIMEOUT) + 1;

  logic [TW-1:0] auto_cnt;

  // Held at zero outside ARMED, so it starts from zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (state != ARMED) begin
      auto_cnt <= '0;
    end else if (smpl_en) begin
      auto_cnt <= auto_cnt + TW'(1);
    end
  end

  assign auto_fire = (state == ARMED) && (auto_cnt == TW'(AUTO_TIMEOUT - 1)) && !trig_in;
`else
  assign auto_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (start_pre_tgt == '0) ? ARMED : PRE;
        end
      end
      PRE: begin
        if (smpl_en && (pre_cnt + AW'(1) == pre_tgt)) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (trig_take) begin
          state_next = (tp_lat == '0) ? DONE : POST;
        end
      end
      POST: begin
        if (smpl_en && (post_cnt == AW'(1))) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    we = smpl_en && (state == PRE || state == ARMED || state == POST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed        <= 1'b0;
      capture_done <= 1'b0;
      triggered    <= 1'b0;
      waddr        <= '0;
      trig_addr    <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      tp_lat       <= '0;
      pre_tgt      <= '0;
    end else begin
      armed        <= (state_next == ARMED);
      capture_done <= (state_next == DONE);

      if (we) begin
        waddr <= waddr + AW'(1);
      end

      if (abort) begin
        triggered <= 1'b0;
      end else if (start_ok) begin
        tp_lat    <= trig_pos;
        pre_tgt   <= start_pre_tgt;
        waddr     <= '0;
        pre_cnt   <= '0;
        triggered <= 1'b0;
      end else begin
        if (state == PRE && smpl_en) begin
          pre_cnt <= pre_cnt + AW'(1);
        end
        if (trig_take) begin
          trig_addr <= waddr;
          triggered <= 1'b1;
          post_cnt  <= tp_lat;
        end
        if (state == POST && smpl_en) begin
          post_cnt <= post_cnt - AW'(1);
        end
      end
    end
  end

endmodule
